// File: rtl/rtr_route_queue.sv
// rtr_route_queue: per-input-VC route holding queue.
// Captures {output port, resource class} of each head flit in arrival order
// and presents the oldest route to the allocators until its tail departs.
// Optional macro RTR_ROUTE_QUEUE_BYPASS_EN: zero-latency head routing when
// the queue is empty (push route driven straight to the outputs).
module rtr_route_queue #(
  parameter int unsigned num_ports            = 5,
  parameter int unsigned num_resource_classes = 2,
  parameter int unsigned queue_depth          = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            push_valid,
  input  logic [num_ports-1:0]            push_op,
  input  logic [num_resource_classes-1:0] push_orc,
  input  logic [1:0]                      push_errors,
  input  logic                            pop,
  output logic                            route_valid,
  output logic [num_ports-1:0]            route_op,
  output logic [num_resource_classes-1:0] route_orc,
  output logic                            full,
  output logic [2:0]                      errors
);

  localparam int unsigned PTR_W = (queue_depth > 1) ? $clog2(queue_depth) : 1;
  localparam int unsigned CNT_W = $clog2(queue_depth + 1);
  localparam int unsigned ENT_W = num_ports + num_resource_classes;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(queue_depth - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(queue_depth);

  logic [ENT_W-1:0] mem_q [queue_depth];
  logic [ENT_W-1:0] mem_d [queue_depth];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             route_valid_q, route_valid_d;
  logic [ENT_W-1:0] route_q, route_d;
  logic             full_q, full_d;
  logic [2:0]       errors_q, errors_d;

  logic push_ok, pop_ok, bypass_hit, is_full, is_empty;

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign is_full  = (count_q == DEPTH_CNT);
  assign is_empty = (count_q == '0);

`ifdef RTR_ROUTE_QUEUE_BYPASS_EN
  assign bypass_hit = push_valid && is_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  // Next-state: storage, pointers, count, sticky errors and registered outputs.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    errors_d = errors_q;

    push_ok = push_valid && (!is_full || pop);
    // A bypassed entry may retire in its own push cycle.
    pop_ok  = pop && (!is_empty || bypass_hit);

    if (push_ok) begin
      mem_d[wr_ptr_q] = {push_op, push_orc};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end

    if (push_valid && is_full && !pop)     errors_d[0] = 1'b1;
    if (pop && is_empty && !bypass_hit)    errors_d[1] = 1'b1;
    if (push_valid && (|push_errors))      errors_d[2] = 1'b1;

    // Outputs are registered from the post-update storage so a push into an
    // empty queue is visible the following cycle and push+pop at count 1 has
    // no bubble.
    route_valid_d = (count_d != '0);
    route_d       = route_valid_d ? mem_d[rd_ptr_d] : '0;
    full_d        = (count_d == DEPTH_CNT);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < queue_depth; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      route_valid_q <= 1'b0;
      route_q       <= '0;
      full_q        <= 1'b0;
      errors_q      <= '0;
    end else begin
      mem_q         <= mem_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      route_valid_q <= route_valid_d;
      route_q       <= route_d;
      full_q        <= full_d;
      errors_q      <= errors_d;
    end
  end

  assign route_valid = bypass_hit ? 1'b1     : route_valid_q;
  assign route_op    = bypass_hit ? push_op  : route_q[ENT_W-1:num_resource_classes];
  assign route_orc   = bypass_hit ? push_orc : route_q[num_resource_classes-1:0];
  assign full        = full_q;
  assign errors      = errors_q;

endmodule

// File: tb/tb_rtr_route_queue.sv
// Self-checking bench for rtr_route_queue: depth-2 instance driven through
// directed steps against a reference queue, plus a depth-3 wrap instance.
module tb_rtr_route_queue;

  logic       clk = 1'b0;
  logic       reset_n;
  // depth-2 instance
  logic       push_valid, pop;
  logic [4:0] push_op;
  logic [1:0] push_orc, push_errors;
  logic       route_valid, full;
  logic [4:0] route_op;
  logic [1:0] route_orc;
  logic [2:0] errors;
  // depth-3 instance
  logic       pv3, pop3;
  logic [4:0] op3;
  logic       rv3, full3;
  logic [4:0] rop3;
  logic [1:0] rorc3;
  logic [2:0] err3;

  int tests = 0;
  int fails = 0;

  logic [6:0] exp_q [$];   // {op, orc}
  logic [2:0] exp_err;
  logic [4:0] exp_q3 [$];

  always #5 clk = ~clk;

  rtr_route_queue #(.num_ports(5), .num_resource_classes(2), .queue_depth(2)) dut (
    .clk(clk), .reset_n(reset_n), .push_valid(push_valid), .push_op(push_op),
    .push_orc(push_orc), .push_errors(push_errors), .pop(pop),
    .route_valid(route_valid), .route_op(route_op), .route_orc(route_orc),
    .full(full), .errors(errors));

  rtr_route_queue #(.num_ports(5), .num_resource_classes(2), .queue_depth(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .push_valid(pv3), .push_op(op3),
    .push_orc(2'b01), .push_errors(2'b00), .pop(pop3),
    .route_valid(rv3), .route_op(rop3), .route_orc(rorc3),
    .full(full3), .errors(err3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    push_valid = 1'b0; push_op = '0; push_orc = '0; push_errors = '0; pop = 1'b0;
    pv3 = 1'b0; op3 = '0; pop3 = 1'b0;
  endtask

  task automatic check_main(input string tag);
    logic [6:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 7'd0;
    chk({tag, ".valid"},  32'(route_valid), 32'(exp_q.size() != 0));
    chk({tag, ".op"},     32'(route_op),    32'(head[6:2]));
    chk({tag, ".orc"},    32'(route_orc),   32'(head[1:0]));
    chk({tag, ".full"},   32'(full),        32'(exp_q.size() == 2));
    chk({tag, ".errors"}, 32'(errors),      32'(exp_err));
  endtask

  // One clock of stimulus on the depth-2 instance, model update, then check.
  task automatic cyc(input string tag, input logic pv, input logic [4:0] op,
                     input logic [1:0] orc, input logic [1:0] perr, input logic pp);
    int  sz;
    logic byp, push_ok, pop_ok;
    push_valid = pv; push_op = op; push_orc = orc; push_errors = perr; pop = pp;
    sz  = exp_q.size();
    byp = 1'b0;
`ifdef RTR_ROUTE_QUEUE_BYPASS_EN
    byp = pv && (sz == 0);
    #1;
    if (byp) begin
      chk({tag, ".byp_valid"}, 32'(route_valid), 32'd1);
      chk({tag, ".byp_op"},    32'(route_op),    32'(op));
      chk({tag, ".byp_orc"},   32'(route_orc),   32'(orc));
    end
`endif
    push_ok = pv && (sz < 2 || pp);
    pop_ok  = pp && (sz != 0 || byp);
    if (pv && sz == 2 && !pp)  exp_err[0] = 1'b1;
    if (pp && sz == 0 && !byp) exp_err[1] = 1'b1;
    if (pv && (|perr))         exp_err[2] = 1'b1;
    if (push_ok) exp_q.push_back({op, orc});
    if (pop_ok)  void'(exp_q.pop_front());
    @(posedge clk); #1;
    idle_inputs();
    #1;
    check_main(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_q.delete();
    exp_err = '0;
    #1;
  endtask

  initial begin
    exp_err = '0;
    idle_inputs();
    do_reset();

    // Reset then idle
    check_main("reset");
    for (int i = 0; i < 10; i++) cyc("idle", 1'b0, 5'b0, 2'b0, 2'b0, 1'b0);

    // Single push, hold, pop
    cyc("push1", 1'b1, 5'b00100, 2'b01, 2'b00, 1'b0);
    cyc("hold1", 1'b0, 5'b0, 2'b0, 2'b00, 1'b0);
    cyc("hold2", 1'b0, 5'b0, 2'b0, 2'b00, 1'b0);
    cyc("pop1",  1'b0, 5'b0, 2'b0, 2'b00, 1'b1);

    // Fill and overflow
    cyc("fill_a", 1'b1, 5'b00010, 2'b10, 2'b00, 1'b0);
    cyc("fill_b", 1'b1, 5'b01000, 2'b01, 2'b00, 1'b0);
    cyc("ovf",    1'b1, 5'b10000, 2'b10, 2'b00, 1'b0);
    cyc("drain_a", 1'b0, 5'b0, 2'b0, 2'b00, 1'b1);
    cyc("drain_b", 1'b0, 5'b0, 2'b0, 2'b00, 1'b1);

    // Push and pop together while full
    cyc("pf_a",  1'b1, 5'b00010, 2'b01, 2'b00, 1'b0);
    cyc("pf_b",  1'b1, 5'b01000, 2'b10, 2'b00, 1'b0);
    cyc("pf_pp", 1'b1, 5'b00001, 2'b01, 2'b00, 1'b1);
    cyc("pf_p1", 1'b0, 5'b0, 2'b0, 2'b00, 1'b1);
    cyc("pf_p2", 1'b0, 5'b0, 2'b0, 2'b00, 1'b1);

    // Push+pop at count 1: no bubble
    cyc("c1_a",  1'b1, 5'b00100, 2'b10, 2'b00, 1'b0);
    cyc("c1_pp", 1'b1, 5'b10000, 2'b01, 2'b00, 1'b1);
    cyc("c1_p",  1'b0, 5'b0, 2'b0, 2'b00, 1'b1);

    // Underflow and filter error, then async reset mid-packet
    do_reset();
    cyc("udf",  1'b0, 5'b0, 2'b0, 2'b00, 1'b1);
    cyc("ferr", 1'b1, 5'b00001, 2'b10, 2'b01, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst.errors", 32'(errors), 32'd0);
    chk("async_rst.valid",  32'(route_valid), 32'd0);
    chk("async_rst.op",     32'(route_op), 32'd0);
    exp_q.delete();
    exp_err = '0;
    @(posedge clk); #1 reset_n = 1'b1;
    #1;
    check_main("post_rst");

    // Depth-3 pointer wrap: 7 push/pop pairs, then fill to full and drain
    for (int i = 0; i < 7; i++) begin
      pv3 = 1'b1; op3 = 5'(i + 1); pop3 = (i > 0);
      exp_q3.push_back(5'(i + 1));
      if (i > 0) void'(exp_q3.pop_front());
      @(posedge clk); #1;
      idle_inputs();
      #1;
      chk("wrap.valid", 32'(rv3), 32'd1);
      chk("wrap.op",    32'(rop3), 32'(exp_q3[0]));
      chk("wrap.err",   32'(err3), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      pv3 = 1'b1; op3 = 5'(i + 20);
      exp_q3.push_back(5'(i + 20));
      @(posedge clk); #1;
      idle_inputs();
      #1;
    end
    chk("wrap.full", 32'(full3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("wrap.drain_op", 32'(rop3), 32'(exp_q3[0]));
      pop3 = 1'b1;
      void'(exp_q3.pop_front());
      @(posedge clk); #1;
      idle_inputs();
      #1;
    end
    chk("wrap.empty", 32'(rv3), 32'd0);
    chk("wrap.err_end", 32'(err3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
